fifo_rd_stream_checker: RTL

Read-side consumer placed directly downstream of the asynchronous FIFO, in the rd_clk domain. The FIFO pops one word on every rd_clk edge where rd_empty is low. This block takes each popped word and checks it against the incrementing byte pattern injected on the write side. It locks onto the stream, counts words and mismatches, and captures the first failing word for debug.

---
 rtl/fifo_rd_stream_checker_pkg.sv | 17 +
 rtl/fifo_rd_stream_checker_if.sv | 28 ++
 rtl/fifo_rd_stream_checker_sat_counter.sv | 25 ++
 rtl/fifo_rd_stream_checker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_checker_pkg.sv
// Shared types for the FIFO read-side stream checker: FSM encoding and saturating increment.
// Pure declarations; no logic of its own.
package fifo_rd_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEED    = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // Counters up to 32 bits share this; callers narrow the result back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_checker_if.sv
// Bundle between the FIFO read side / debug host and the stream checker.
// The FIFO side drives data and control, the checker drives status.
interface fifo_rd_stream_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] data_in;
    logic             rd_empty;
    logic             enable;
    logic             clear;
    logic             locked;
    logic             err_flag;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] exp_data;
    logic [WIDTH-1:0] first_err_data;
    logic [WIDTH-1:0] first_err_exp;

    modport master (
        output data_in, rd_empty, enable, clear,
        input  locked, err_flag, word_count, err_count, exp_data, first_err_data, first_err_exp
    );

    modport slave (
        input  data_in, rd_empty, enable, clear,
        output locked, err_flag, word_count, err_count, exp_data, first_err_data, first_err_exp
    );
endinterface

// File: rtl/fifo_rd_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: one edge; no backpressure, inc is taken every edge it is high.
module sat_counter
    import fifo_rd_stream_checker_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    localparam logic [31:0] MAX_V = 32'((64'd1 << W) - 64'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= W'(sat_inc(32'(count), MAX_V));
        end
    end
endmodule

// File: rtl/fifo_rd_stream_checker.sv
// Checks FIFO read-side words against the incrementing write-side pattern; locks, counts, captures first error.
// Latency: outputs registered, one edge after the accepting edge; no backpressure, every popped word is evaluated once.
module fifo_rd_stream_checker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4
) (
    input  logic                    rd_clk,
    input  logic                    reset_n,
    fifo_rd_stream_checker_if.slave bus
);
    import fifo_rd_stream_checker_pkg::*;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [3:0]       LOCK_TH = 4'(LOCK_N);

    state_e           state, state_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [3:0]       match_cnt, match_cnt_n;
    logic             err_flag_q;
    logic             first_seen;
    logic [WIDTH-1:0] first_err_data_q;
    logic [WIDTH-1:0] first_err_exp_q;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    logic accept;
    logic match;
    logic word_inc;
    logic err_inc;
    logic capture;

    assign accept = bus.enable & ~bus.rd_empty;
    assign match  = (bus.data_in == exp_q);

    always_comb begin
        state_n     = state;
        exp_n       = exp_q;
        match_cnt_n = match_cnt;
        word_inc    = 1'b0;
        err_inc     = 1'b0;
        capture     = 1'b0;

        if (bus.clear) begin
            // Word on a clear edge is dropped; the next accepted word reseeds in ACQUIRE.
            state_n     = bus.enable ? ST_ACQUIRE : ST_IDLE;
            match_cnt_n = '0;
        end else if (!bus.enable) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_n = ST_SEED;
                end
                ST_SEED: begin
                    if (accept) begin
                        word_inc    = 1'b1;
                        exp_n       = bus.data_in + ONE;
                        match_cnt_n = 4'd1;
                        state_n     = (LOCK_N == 1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (accept) begin
                        word_inc = 1'b1;
                        if (match) begin
                            exp_n       = exp_q + ONE;
                            match_cnt_n = match_cnt + 4'd1;
                            if (match_cnt + 4'd1 >= LOCK_TH) begin
                                state_n = ST_LOCKED;
                            end
                        end else begin
                            exp_n       = bus.data_in + ONE;
                            match_cnt_n = 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        word_inc = 1'b1;
                        if (match) begin
                            exp_n = exp_q + ONE;
                        end else begin
                            // Resync on the received value so a single drop costs one error.
                            exp_n   = bus.data_in + ONE;
                            err_inc = 1'b1;
                            capture = ~first_seen;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            exp_q     <= '0;
            match_cnt <= '0;
        end else begin
            state     <= state_n;
            exp_q     <= exp_n;
            match_cnt <= match_cnt_n;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!reset_n || bus.clear) begin
            err_flag_q       <= 1'b0;
            first_seen       <= 1'b0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
        end else begin
            if (err_inc) begin
                err_flag_q <= 1'b1;
            end
            if (capture) begin
                first_seen       <= 1'b1;
                first_err_data_q <= bus.data_in;
                first_err_exp_q  <= exp_q;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk     (rd_clk),
        .reset_n (reset_n),
        .clr     (bus.clear),
        .inc     (word_inc),
        .count   (word_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (rd_clk),
        .reset_n (reset_n),
        .clr     (bus.clear),
        .inc     (err_inc),
        .count   (err_count)
    );

    assign bus.locked         = (state == ST_LOCKED);
    assign bus.err_flag       = err_flag_q;
    assign bus.word_count     = word_count;
    assign bus.err_count      = err_count;
    assign bus.exp_data       = exp_q;
    assign bus.first_err_data = first_err_data_q;
    assign bus.first_err_exp  = first_err_exp_q;
endmodule
